muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS-style datapath. Consumes the two operands read from the register file (`ReadData1`, `ReadData2`) and produces a 2×Dbits result in HI/LO registers for later `mfhi`/`mflo` writeback. Uses one shift-add or restoring-divide step per clock, with a start/busy/done handshake to the controller.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// clock, sign fix-up in a final cycle, result held in HI/LO until the next FIX.
module muldiv_unit #(
  parameter int Dbits = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [Dbits-1:0] a,
  input  logic [Dbits-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [Dbits-1:0] hi,
  output logic [Dbits-1:0] lo
);
  localparam int CW = $clog2(Dbits + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_q, sign_d;     // product / quotient negative
  logic             rsign_q, rsign_d;   // remainder negative
  logic             bz_q, bz_d;         // divisor was zero
  logic [Dbits-1:0] ain_q, ain_d;       // original a, returned as HI on div-by-zero
  logic [Dbits-1:0] bm_q, bm_d;         // |b|: multiplicand or divisor
  // Multiply: HI half accumulates, LO half shifts out multiplier bits.
  // Divide: LO half shifts dividend bits out and quotient bits in.
  logic [2*Dbits-1:0] acc_q, acc_d;
  logic [Dbits-1:0] rem_q, rem_d;
  logic [Dbits-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [Dbits-1:0]   a_mag, b_mag;
  logic [Dbits:0]     mul_sum, trial, diff;
  logic               ge;
  logic [2*Dbits-1:0] prod_fix;
  logic [Dbits-1:0]   quo_fix, rem_fix;

  // Datapath helpers: operand magnitudes, one iteration step, sign fix-up
  always_comb begin
    a_mag    = (op[0] && a[Dbits-1]) ? -a : a;
    b_mag    = (op[0] && b[Dbits-1]) ? -b : b;
    mul_sum  = {1'b0, acc_q[2*Dbits-1:Dbits]} + (acc_q[0] ? {1'b0, bm_q} : '0);
    // Dbits+1-bit trial remainder keeps the bit shifted out of rem_q
    trial    = {rem_q, acc_q[Dbits-1]};
    ge       = trial >= {1'b0, bm_q};
    diff     = trial - {1'b0, bm_q};
    prod_fix = sign_q ? -acc_q : acc_q;
    quo_fix  = sign_q ? -acc_q[Dbits-1:0] : acc_q[Dbits-1:0];
    rem_fix  = rsign_q ? -rem_q : rem_q;
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    bz_d     = bz_q;
    ain_d    = ain_q;
    bm_d     = bm_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = done_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          state_d  = RUN;
          cnt_d    = CW'(Dbits);
          is_div_d = op[1];
          sign_d   = op[0] & (a[Dbits-1] ^ b[Dbits-1]);
          rsign_d  = op[0] & a[Dbits-1];
          bz_d     = (b == '0);
          ain_d    = a;
          bm_d     = b_mag;
          acc_d    = {{Dbits{1'b0}}, a_mag};
          rem_d    = '0;
          dbz_d    = 1'b0;
        end
      end
      RUN: begin
        if (is_div_q) begin
          rem_d              = ge ? diff[Dbits-1:0] : trial[Dbits-1:0];
          acc_d[Dbits-1:0]   = {acc_q[Dbits-2:0], ge};
        end else begin
          acc_d = {mul_sum, acc_q[Dbits-1:1]};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (bz_q) begin
            hi_d  = ain_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; enable freezes everything, reset overrides enable
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      bz_q     <= 1'b0;
      ain_q    <= '0;
      bm_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      bz_q     <= bz_d;
      ain_q    <= ain_d;
      bm_q     <= bm_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;
  localparam int D = 32;

  logic         clock = 1'b0, reset_n = 1'b0, enable = 1'b1, start = 1'b0;
  logic [1:0]   op = '0;
  logic [D-1:0] a = '0, b = '0;
  logic         busy, done, div_by_zero;
  logic [D-1:0] hi, lo;

  int n_tests = 0, n_fail = 0;
  logic [D-1:0] prev_hi = '0, prev_lo = '0;

  muldiv_unit #(.Dbits(D)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
    .op(op), .a(a), .b(b), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: MIPS mult/div semantics via 64-bit integer arithmetic
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] eh, output logic [31:0] el, output logic ez);
    logic [63:0] p;
    longint sx, sy, q, r;
    ez = 1'b0;
    eh = '0;
    el = '0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; end
      2'd1: begin p = sx * sy; {eh, el} = p; end
      default: begin
        if (y == 0) begin
          eh = x; el = '1; ez = 1'b1;
        end else if (o == 2'd2) begin
          el = x / y; eh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int stall_at, input int stall_len, input bit junk,
                        input string tag);
    logic [31:0] eh, el;
    logic ez;
    int n;
    bit got, hold_bad;
    model(o, x, y, eh, el, ez);
    op = o; a = x; b = y; start = 1'b1; enable = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_dbz_clr"}, 64'(div_by_zero), 64'd0);
    n = 0; got = 0; hold_bad = 0;
    while (n < 100 && !got) begin
      enable = !(n >= stall_at && n < stall_at + stall_len);
      if (junk) begin
        start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      @(posedge clock); #1;
      n++;
      if (done) got = 1;
      else if (hi !== prev_hi || lo !== prev_lo) hold_bad = 1;
    end
    start = 1'b0; enable = 1'b1;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(D + 1 + stall_len));
    chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    prev_hi = eh; prev_lo = el;
  endtask

  // One idle cycle after done: done must drop, results stay put
  task automatic idle_gap(input string tag);
    @(posedge clock); #1;
    chk({tag, "_done_fall"}, 64'(done), 64'd0);
    chk({tag, "_hold_idle"}, {hi, lo}, {prev_hi, prev_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset with start held: must be ignored
    reset_n = 1'b0; start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    start = 1'b0; reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rst_rel_busy", 64'(busy), 64'd0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, "multu_max");
    chk("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(lo), 64'h1);
    idle_gap("multu_max");
    run_op(2'd1, -32'sd3, 32'd7, 0, 0, 0, "mult_neg");
    chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    idle_gap("mult_neg");
    run_op(2'd3, -32'sd7, 32'd2, 0, 0, 0, "div_neg");
    chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    idle_gap("div_neg");
    run_op(2'd2, 32'd100, 32'd0, 0, 0, 0, "divu_zero");
    chk("divu_zero_const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    idle_gap("divu_zero");
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, "div_ovf");
    chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
    idle_gap("div_ovf");
    // Stall mid-RUN with junk starts, then back-to-back start on done
    run_op(2'd2, 32'd1000, 32'd7, 10, 5, 1, "divu_stall");
    chk("divu_stall_const", {hi, lo}, {32'd6, 32'd142});
    run_op(2'd0, 32'd6, 32'd7, 0, 0, 0, "b2b_multu");
    chk("b2b_const", {hi, lo}, 64'd42);
    idle_gap("b2b");

    // Reset mid-RUN discards the operation
    op = 2'd1; a = 32'd123; b = 32'd456; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    reset_n = 1'b1;
    prev_hi = '0; prev_lo = '0;
    @(posedge clock); #1;
    chk("midrst_idle", 64'(busy), 64'd0);

    // Randomized operations with random stalls, junk starts and gaps
    for (int i = 0; i < 40; i++) begin
      int sa, sl;
      sa = $urandom_range(1, 30);
      sl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      run_op(2'($urandom), pick(), pick(), sa, sl, bit'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle_gap($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
